// File: rtl/quantum_scheduler_pkg.sv
// Shared encodings for the round-robin quantum scheduler.
package quantum_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_KERNEL = 2'b00,
    ST_RUN    = 2'b01,
    ST_SWAP   = 2'b10
  } sched_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'b00,
    CAUSE_EXPIRY = 2'b01,
    CAUSE_YIELD  = 2'b10,
    CAUSE_EXIT   = 2'b11
  } swap_cause_t;

  localparam int unsigned KERNEL_PID = 0;

endpackage

// File: rtl/quantum_scheduler_rr_pick.sv
// Wrapping priority search for the next runnable user PID after last_pid.
module rr_pick #(
  parameter int unsigned NPROC = 8,
  parameter int unsigned PID_W = 3
) (
  input  logic [NPROC-1:0] ready_mask,
  input  logic [PID_W-1:0] last_pid,
  output logic [PID_W-1:0] pick_pid,
  output logic             pick_valid
);
  import quantum_scheduler_pkg::*;

  // Scan farthest-first so the nearest candidate after last_pid wins; offset
  // NPROC lands on last_pid itself, making it the lowest-priority candidate.
  always_comb begin
    logic [PID_W-1:0] idx;
    pick_pid   = '0;
    pick_valid = 1'b0;
    for (int unsigned k = NPROC; k >= 1; k--) begin
      idx = PID_W'(32'(last_pid) + k);
      if (idx != PID_W'(KERNEL_PID) && ready_mask[idx]) begin
        pick_pid   = idx;
        pick_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/quantum_scheduler.sv
// Round-robin preemptive process scheduler: PID ownership, time slice, swaps.
module quantum_scheduler #(
  parameter int unsigned NPROC   = 8,
  parameter int unsigned PID_W   = 3,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned QUANTUM = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [NPROC-1:0] ready_mask,
  input  logic             set_pid_valid,
  input  logic [PID_W-1:0] set_pid_value,
  input  logic             rr_req,
  input  logic             proc_exit,
  input  logic             io_stall,
  input  logic             swap_ack,
  output logic             swap_req,
  output logic [1:0]       swap_cause,
  output logic [PID_W-1:0] cur_pid,
  output logic             kernel_mode,
  output logic             dispatch,
  output logic             set_pid_err,
  output logic             idle
);
  import quantum_scheduler_pkg::*;

  sched_state_t     state;
  swap_cause_t      cause_q;
  logic [PID_W-1:0] last_pid;
  logic [CNT_W-1:0] counter;
  logic [PID_W-1:0] pick_pid;
  logic             pick_valid;
  logic             tick_ok;

  rr_pick #(
    .NPROC(NPROC),
    .PID_W(PID_W)
  ) u_pick (
    .ready_mask(ready_mask),
    .last_pid  (last_pid),
    .pick_pid  (pick_pid),
    .pick_valid(pick_valid)
  );

  // Status lines derived from the registered state.
  always_comb begin
    tick_ok     = enable && !io_stall;
    kernel_mode = (cur_pid == PID_W'(KERNEL_PID));
    idle        = (state == ST_KERNEL) && !pick_valid;
    swap_cause  = cause_q;
  end

  // Scheduler FSM with registered outputs and slice counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_KERNEL;
      cur_pid     <= '0;
      last_pid    <= '0;
      counter     <= '0;
      swap_req    <= 1'b0;
      cause_q     <= CAUSE_NONE;
      dispatch    <= 1'b0;
      set_pid_err <= 1'b0;
    end else begin
      dispatch    <= 1'b0;
      set_pid_err <= 1'b0;
      case (state)
        ST_KERNEL: begin
          if (set_pid_valid) begin
            if (set_pid_value != PID_W'(KERNEL_PID) && ready_mask[set_pid_value]) begin
              state    <= ST_RUN;
              cur_pid  <= set_pid_value;
              counter  <= CNT_W'(QUANTUM - 1);
              dispatch <= 1'b1;
            end else begin
              set_pid_err <= 1'b1;
            end
          end else if (rr_req && pick_valid) begin
            state    <= ST_RUN;
            cur_pid  <= pick_pid;
            counter  <= CNT_W'(QUANTUM - 1);
            dispatch <= 1'b1;
          end
        end
        ST_RUN: begin
          if (proc_exit) begin
            state    <= ST_SWAP;
            swap_req <= 1'b1;
            cause_q  <= CAUSE_EXIT;
          end else if (rr_req) begin
            state    <= ST_SWAP;
            swap_req <= 1'b1;
            cause_q  <= CAUSE_YIELD;
          end else if (tick_ok && counter == '0) begin
            state    <= ST_SWAP;
            swap_req <= 1'b1;
            cause_q  <= CAUSE_EXPIRY;
          end else if (tick_ok) begin
            counter <= counter - 1'b1;
          end
        end
        ST_SWAP: begin
          if (swap_ack) begin
            state    <= ST_KERNEL;
            last_pid <= cur_pid;
            cur_pid  <= '0;
            swap_req <= 1'b0;
            cause_q  <= CAUSE_NONE;
          end
        end
        default: state <= ST_KERNEL;
      endcase
    end
  end

endmodule

// File: tb/tb_quantum_scheduler.sv
// Self-checking bench for quantum_scheduler: behavioural model plus directed
// scenarios and a randomized phase.
module tb_quantum_scheduler;
  localparam int NPROC = 8;
  localparam int PID_W = 3;
  localparam int QUANTUM = 64;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b1;
  logic [NPROC-1:0] ready_mask = '0;
  logic             set_pid_valid = 1'b0;
  logic [PID_W-1:0] set_pid_value = '0;
  logic             rr_req = 1'b0;
  logic             proc_exit = 1'b0;
  logic             io_stall = 1'b0;
  logic             swap_ack = 1'b0;
  logic             swap_req;
  logic [1:0]       swap_cause;
  logic [PID_W-1:0] cur_pid;
  logic             kernel_mode;
  logic             dispatch;
  logic             set_pid_err;
  logic             idle;

  int checks = 0;
  int failures = 0;

  quantum_scheduler #(
    .NPROC(NPROC), .PID_W(PID_W), .CNT_W(16), .QUANTUM(QUANTUM)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .ready_mask(ready_mask),
    .set_pid_valid(set_pid_valid), .set_pid_value(set_pid_value),
    .rr_req(rr_req), .proc_exit(proc_exit), .io_stall(io_stall),
    .swap_ack(swap_ack), .swap_req(swap_req), .swap_cause(swap_cause),
    .cur_pid(cur_pid), .kernel_mode(kernel_mode), .dispatch(dispatch),
    .set_pid_err(set_pid_err), .idle(idle)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 = kernel, 1 = user running, 2 = awaiting ack.
  int m_mode, m_pid, m_last, m_used, m_cause;
  bit m_disp, m_err;

  function automatic int next_ready(input int last, input logic [NPROC-1:0] mask);
    for (int k = 1; k <= NPROC; k++) begin
      int p;
      p = (last + k) % NPROC;
      if (p != 0 && mask[p]) return p;
    end
    return -1;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_mode = 0; m_pid = 0; m_last = 0; m_used = 0; m_cause = 0;
      m_disp = 0; m_err = 0;
    end else begin
      int nxt;
      bit active;
      m_disp = 0;
      m_err = 0;
      active = enable && !io_stall;
      nxt = next_ready(m_last, ready_mask);
      if (m_mode == 0) begin
        if (set_pid_valid) begin
          if (set_pid_value != 0 && ready_mask[set_pid_value]) begin
            m_mode = 1; m_pid = int'(set_pid_value); m_used = 0; m_disp = 1;
          end else begin
            m_err = 1;
          end
        end else if (rr_req && nxt >= 0) begin
          m_mode = 1; m_pid = nxt; m_used = 0; m_disp = 1;
        end
      end else if (m_mode == 1) begin
        if (proc_exit) begin
          m_mode = 2; m_cause = 3;
        end else if (rr_req) begin
          m_mode = 2; m_cause = 2;
        end else if (active) begin
          if (m_used == QUANTUM - 1) begin
            m_mode = 2; m_cause = 1;
          end else begin
            m_used++;
          end
        end
      end else if (swap_ack) begin
        m_mode = 0; m_last = m_pid; m_pid = 0; m_cause = 0;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clock) begin
    if (!reset) begin
      chk("cur_pid", int'(cur_pid), m_pid);
      chk("kernel_mode", int'(kernel_mode), int'(m_pid == 0));
      chk("swap_req", int'(swap_req), int'(m_mode == 2));
      chk("swap_cause", int'(swap_cause), m_cause);
      chk("dispatch", int'(dispatch), int'(m_disp));
      chk("set_pid_err", int'(set_pid_err), int'(m_err));
      chk("idle", int'(idle), int'(m_mode == 0 && next_ready(m_last, ready_mask) < 0));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic quiet();
    set_pid_valid = 0; rr_req = 0; proc_exit = 0; swap_ack = 0;
    io_stall = 0; enable = 1;
  endtask

  task automatic do_exit_ack();
    proc_exit = 1; tick(); proc_exit = 0;
    swap_ack = 1; tick(); swap_ack = 0;
  endtask

  task automatic set_pid(input int v);
    set_pid_valid = 1; set_pid_value = PID_W'(v); tick(); set_pid_valid = 0;
  endtask

  initial begin
    quiet();
    repeat (3) @(posedge clock);
    #1 reset = 0;
    @(negedge clock);
    chk("rst_cur_pid", int'(cur_pid), 0);
    chk("rst_kernel_mode", int'(kernel_mode), 1);
    chk("rst_swap_req", int'(swap_req), 0);
    chk("rst_idle", int'(idle), 1);
    tick();

    // Round-robin dispatch and full-quantum expiry.
    ready_mask = 8'b0000_0110;
    rr_req = 1; tick(); rr_req = 0;
    @(negedge clock);
    chk("rr_dispatch", int'(dispatch), 1);
    chk("rr_pid", int'(cur_pid), 1);
    chk("rr_user_mode", int'(kernel_mode), 0);
    chk("model_rr_pid", m_pid, 1);
    repeat (63) tick();
    @(negedge clock);
    chk("pre_expiry_req", int'(swap_req), 0);
    tick();
    @(negedge clock);
    chk("expiry_req", int'(swap_req), 1);
    chk("expiry_cause", int'(swap_cause), 1);
    swap_ack = 1; tick(); swap_ack = 0;
    @(negedge clock);
    chk("ack_pid", int'(cur_pid), 0);
    rr_req = 1; tick(); rr_req = 0;
    @(negedge clock);
    chk("rr_next_pid", int'(cur_pid), 2);
    do_exit_ack();

    // Rejected then accepted SET_PID.
    ready_mask = 8'b0000_1110;
    set_pid(5);
    @(negedge clock);
    chk("setpid_err", int'(set_pid_err), 1);
    chk("setpid_err_pid", int'(cur_pid), 0);
    set_pid(3);
    @(negedge clock);
    chk("setpid_pid", int'(cur_pid), 3);
    chk("setpid_dispatch", int'(dispatch), 1);

    // Expiry deferred across an io_stall at counter 1.
    repeat (62) tick();
    io_stall = 1;
    repeat (10) tick();
    @(negedge clock);
    chk("stall_no_swap", int'(swap_req), 0);
    io_stall = 0; tick();
    @(negedge clock);
    chk("stall_last_dec", int'(swap_req), 0);
    tick();
    @(negedge clock);
    chk("stall_expiry", int'(swap_req), 1);
    chk("stall_cause", int'(swap_cause), 1);
    swap_ack = 1; tick(); swap_ack = 0;

    // Exit, yield and expiry coincide: exit wins; cause held until ack.
    rr_req = 1; tick(); rr_req = 0;
    repeat (63) tick();
    proc_exit = 1; rr_req = 1; tick(); proc_exit = 0; rr_req = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("hold_req", int'(swap_req), 1);
      chk("hold_cause", int'(swap_cause), 3);
      tick();
    end
    swap_ack = 1; tick(); swap_ack = 0;
    @(negedge clock);
    chk("ack_clear_req", int'(swap_req), 0);
    chk("ack_clear_cause", int'(swap_cause), 0);

    // Wrap past PID 0, and sole-ready re-dispatch of last_pid.
    ready_mask = 8'b1000_0010;
    set_pid(7);
    do_exit_ack();
    rr_req = 1; tick(); rr_req = 0;
    @(negedge clock);
    chk("wrap_pid", int'(cur_pid), 1);
    chk("model_wrap_pid", m_pid, 1);
    do_exit_ack();
    set_pid(7);
    do_exit_ack();
    ready_mask = 8'b1000_0000;
    rr_req = 1; tick(); rr_req = 0;
    @(negedge clock);
    chk("sole_pid", int'(cur_pid), 7);
    chk("model_sole_pid", m_pid, 7);

    // Asynchronous reset in the middle of SWAP.
    tick();
    proc_exit = 1; tick(); proc_exit = 0;
    #2 reset = 1;
    #1;
    chk("async_swap_req", int'(swap_req), 0);
    chk("async_cur_pid", int'(cur_pid), 0);
    ready_mask = '0;
    #1;
    chk("async_idle", int'(idle), 1);
    tick();
    reset = 0;

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      tick();
      enable        = ($urandom_range(0, 9) != 0);
      io_stall      = ($urandom_range(0, 6) == 0);
      set_pid_valid = ($urandom_range(0, 9) == 0);
      set_pid_value = PID_W'($urandom_range(0, NPROC - 1));
      rr_req        = ($urandom_range(0, 11) == 0);
      proc_exit     = ($urandom_range(0, 40) == 0);
      swap_ack      = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) ready_mask = NPROC'($urandom);
    end
    tick();
    quiet();
    tick();
    @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
